pixel_write_queue: RTL and testbench
====================================

// Module: pixel_write_queue
// PURPOSE
//  Buffers pixel writes produced by rasterizer_unit (fb_we/rast_x/rast_y/fb_data).
//  Converts each write to a linear framebuffer address and drains it into the single
//  framebuffer write port, only on cycles the memory arbiter grants access
//  (scanout has priority).
//  Also owns the frame-clear engine: fills the whole framebuffer with one colour
//  before a frame is rasterized.
// PARAMETERS
//  DEPTH     16   FIFO entries, power of two, >=2
//  WIDTH_PX  320  framebuffer width in pixels
//  HEIGHT_PX 240  framebuffer height in pixels
//  ADDR_W    17   framebuffer address width; must satisfy WIDTH_PX*HEIGHT_PX <= 2**ADDR_W
//  DATA_W    4    pixel colour width
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  sreset_n     in   1       synchronous reset, active low
//  fb_we        in   1       rasterizer pixel write strobe (no stall: one pixel/cycle max)
//  rast_x       in   10      pixel column
//  rast_y       in   10      pixel row
//  fb_data      in   DATA_W  pixel colour
//  in_ready     out  1       queue can accept fb_we this cycle
//  clear_start  in   1       one-cycle pulse: request framebuffer clear
//  clear_color  in   DATA_W  fill colour, sampled on accepted clear_start
//  clear_busy   out  1       clear sequence (flush + fill) in progress
//  mem_grant    in   1       arbiter allows a framebuffer write this cycle
//  mem_we       out  1       framebuffer write enable
//  mem_addr     out  ADDR_W  framebuffer write address
//  mem_wdata    out  DATA_W  framebuffer write data
//  overflow     out  1       sticky: an in-range fb_we was dropped; cleared only by reset
//  drop_count   out  16      count of dropped fb_we (out-of-range or not ready); saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (sreset_n=0 at posedge):
//   - state RUN, FIFO empty, clear address 0.
//   - mem_we=0, mem_addr=0, mem_wdata=0, clear_busy=0, overflow=0, drop_count=0.
//   - in_ready=1 on the first cycle after reset.
//   - Reset mid-clear or mid-drain aborts; queued pixels are discarded.
//  Push: fb_we & in_ready & rast_x<WIDTH_PX & rast_y<HEIGHT_PX.
//   - Stores {rast_x + WIDTH_PX*rast_y, fb_data}; the address is computed at push,
//     truncated to ADDR_W.
//  Drops:
//   - Out-of-range fb_we: drop_count+1 only; overflow is unchanged.
//   - In-range fb_we with in_ready=0: drop_count+1 and overflow<=1.
//  in_ready = (state==RUN) & (count<DEPTH). No full bypass: a push is refused when full,
//   even if a pop occurs in the same cycle.
//  States:
//   - RUN:   mem_we = mem_grant & !empty, combinational from registered FIFO head.
//            Pop on the same edge. Simultaneous push+pop leaves count unchanged.
//            clear_start -> FLUSH; clear_color is latched.
//   - FLUSH: drain as in RUN, no pushes. When empty -> CLEAR with clear address 0.
//            If already empty at clear_start, FLUSH lasts exactly one cycle.
//   - CLEAR: mem_we = mem_grant, mem_addr = clear address, mem_wdata = latched colour.
//            Clear address +1 per granted cycle. A granted write at
//            WIDTH_PX*HEIGHT_PX-1 -> RUN next cycle.
//  clear_busy = (state != RUN). clear_start outside RUN is ignored.
//  Latency: a pixel pushed at edge N can appear on mem_we in the cycle after edge N.
//   FIFO order is preserved.
//  mem_addr/mem_wdata hold the head entry (or last value) when mem_we=0. They are
//   don't-care for memory.
//  Full clear with mem_grant stuck at 1:
//   - 1 FLUSH cycle + WIDTH_PX*HEIGHT_PX CLEAR cycles (76801 cycles with defaults).
// TESTING
//  1. Reset, then fb_we on x=10,y=2,data=4'h7 with grant=1 -> next cycle mem_we=1,
//     addr=650, wdata=7; queue empty after.
//  2. grant=0, push 16 pixels in sequence, then push a 17th -> in_ready=0 after the 16th.
//     17th is dropped, overflow=1, drop_count=1. Raise grant -> 16 writes in push order.
//  3. fb_we with x=320,y=0 and with x=0,y=240 -> no write, drop_count=2, overflow=0.
//  4. Queue 3 pixels with grant=0, pulse clear_start (color 4'hA), grant=1:
//     - 3 pixel writes first, then addr 0..76799 data A, then clear_busy=0.
//  5. During CLEAR, toggle grant 50% -> clear address advances only on granted cycles.
//     No address is skipped or repeated.
//  6. Assert sreset_n=0 mid-CLEAR -> next cycle mem_we=0, clear_busy=0, in_ready=1,
//     counters 0.
//  7. Hold in-range fb_we with grant=0 until drop_count saturates -> drop_count holds
//     16'hFFFF and does not wrap.

Source files
------------

// File: rtl/pixel_write_queue_if.sv
// pixel_write_queue_if: rasterizer, clear-control and framebuffer-port signals of the pixel write queue
//   master: driver side (rasterizer, clear requester, memory arbiter)
//   slave : the queue itself (accepts pixels, issues framebuffer writes, reports status)
interface pixel_write_queue_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 4
);
    logic              fb_we;
    logic [9:0]        rast_x;
    logic [9:0]        rast_y;
    logic [DATA_W-1:0] fb_data;
    logic              in_ready;
    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic              mem_grant;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              overflow;
    logic [15:0]       drop_count;

    modport master (
        output fb_we, rast_x, rast_y, fb_data, clear_start, clear_color, mem_grant,
        input  in_ready, clear_busy, mem_we, mem_addr, mem_wdata, overflow, drop_count
    );

    modport slave (
        input  fb_we, rast_x, rast_y, fb_data, clear_start, clear_color, mem_grant,
        output in_ready, clear_busy, mem_we, mem_addr, mem_wdata, overflow, drop_count
    );
endinterface

// File: rtl/pixel_write_queue.sv
// pixel_write_queue: buffers rasterizer pixel writes, linearises their addresses and drains them into the
// framebuffer write port on granted cycles; also runs the flush-then-fill frame-clear sequence.
//   clk_i      : system clock, posedge
//   sreset_n_i : synchronous reset, active low
//   bus        : pixel input (fb_we/rast_x/rast_y/fb_data/in_ready), clear control
//                (clear_start/clear_color/clear_busy), framebuffer port (mem_grant/mem_we/mem_addr/mem_wdata),
//                status (overflow/drop_count)
module pixel_write_queue #(
    parameter int DEPTH     = 16,
    parameter int WIDTH_PX  = 320,
    parameter int HEIGHT_PX = 240,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 4
) (
    input logic               clk_i,
    input logic               sreset_n_i,
    pixel_write_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TOTAL = WIDTH_PX * HEIGHT_PX;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, CLEAR} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d, last_addr_q;
    logic [DATA_W-1:0] color_q, last_data_q;
    logic              overflow_q;
    logic [15:0]       drop_q;
    logic              in_range, in_ready, push, pop, empty, last_px;

    assign in_range = (32'(bus.rast_x) < 32'(WIDTH_PX)) && (32'(bus.rast_y) < 32'(HEIGHT_PX));
    assign empty    = count_q == '0;
    // No full bypass: a full queue refuses a push even when a pop happens on the same edge.
    assign in_ready = (state_q == RUN) && (count_q < DEPTH_C);
    assign push     = bus.fb_we && in_ready && in_range;
    assign pop      = (state_q != CLEAR) && bus.mem_grant && !empty;
    assign last_px  = clr_addr_q == ADDR_W'(TOTAL - 1);
    assign count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            RUN:   state_d = bus.clear_start ? FLUSH : RUN;
            FLUSH: begin
                state_d    = empty ? CLEAR : FLUSH;
                clr_addr_d = '0;
            end
            CLEAR: if (bus.mem_grant) begin
                clr_addr_d = clr_addr_q + 1'b1;
                state_d    = last_px ? RUN : CLEAR;
            end
            default: state_d = RUN;
        endcase
    end

    // When nothing is queued the port shows the last written value rather than a stale FIFO slot.
    assign bus.mem_we     = (state_q == CLEAR) ? bus.mem_grant : pop;
    assign bus.mem_addr   = (state_q == CLEAR) ? clr_addr_q : empty ? last_addr_q : fifo_addr_q[rd_ptr_q];
    assign bus.mem_wdata  = (state_q == CLEAR) ? color_q    : empty ? last_data_q : fifo_data_q[rd_ptr_q];
    assign bus.in_ready   = in_ready;
    assign bus.clear_busy = state_q != RUN;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ADDR_W'(32'(bus.rast_x) + 32'(WIDTH_PX) * 32'(bus.rast_y));
            fifo_data_q[wr_ptr_q] <= bus.fb_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sreset_n_i) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            clr_addr_q  <= '0;
            color_q     <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (state_q == RUN && bus.clear_start) color_q <= bus.clear_color;
            if (bus.mem_we) begin
                last_addr_q <= bus.mem_addr;
                last_data_q <= bus.mem_wdata;
            end
            if (bus.fb_we && in_range && !in_ready) overflow_q <= 1'b1;
            if (bus.fb_we && !push && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_pixel_write_queue.sv
// tb_pixel_write_queue: directed self-checking bench for pixel_write_queue (reduced frame height keeps full clears short)
module tb_pixel_write_queue;
    localparam int W = 320;
    localparam int H = 12;
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    logic sreset_n = 1'b0;
    int checks = 0;
    int errors = 0;

    pixel_write_queue_if #(.ADDR_W(17), .DATA_W(4)) bus();

    pixel_write_queue #(.DEPTH(16), .WIDTH_PX(W), .HEIGHT_PX(H), .ADDR_W(17), .DATA_W(4)) dut (
        .clk_i(clk),
        .sreset_n_i(sreset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        sreset_n = 1'b0;
        bus.fb_we = 1'b0;
        bus.rast_x = '0;
        bus.rast_y = '0;
        bus.fb_data = '0;
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
        bus.mem_grant = 1'b0;
        repeat (2) step();
        sreset_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 17'd0 || bus.mem_wdata !== 4'd0) begin
            errors++;
            $display("FAIL reset_port: we=%b addr=%0d data=%0h, required 0/0/0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.clear_busy !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_status: busy=%b ovf=%b drops=%0d, required 0/0/0", bus.clear_busy, bus.overflow, bus.drop_count);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_single;
        do_reset();
        bus.mem_grant = 1'b1;
        bus.fb_we = 1'b1;
        bus.rast_x = 10'd10;
        bus.rast_y = 10'd2;
        bus.fb_data = 4'h7;
        step();
        bus.fb_we = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'd650 || bus.mem_wdata !== 4'h7) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d data=%0h, required 1/650/7", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        checks++;
        if (bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: mem_we=%b, required 0", bus.mem_we);
        end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.fb_we = 1'b1;
            bus.rast_x = 10'(i);
            bus.rast_y = 10'd1;
            bus.fb_data = 4'(i);
            step();
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: in_ready=%b, required 0", bus.in_ready);
        end
        bus.rast_x = 10'd100;
        bus.rast_y = 10'd0;
        step();
        bus.fb_we = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 16'd1) begin
            errors++;
            $display("FAIL full_drop: ovf=%b drops=%0d, required 1/1", bus.overflow, bus.drop_count);
        end
        bus.mem_grant = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'(320 + i) || bus.mem_wdata !== 4'(i)) begin
                errors++;
                $display("FAIL full_drain%0d: we=%b addr=%0d data=%0h, required 1/%0d/%0h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, 320 + i, i);
            end
            step();
        end
        checks++;
        if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after: we=%b ready=%b, required 0/1", bus.mem_we, bus.in_ready);
        end
    endtask

    task automatic test_range;
        do_reset();
        bus.mem_grant = 1'b1;
        bus.fb_we = 1'b1;
        bus.rast_x = 10'd320;
        bus.rast_y = 10'd0;
        step();
        checks++;
        if (bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL range_x: mem_we=%b, required 0", bus.mem_we);
        end
        bus.rast_x = 10'd0;
        bus.rast_y = 10'd240;
        step();
        bus.fb_we = 1'b0;
        #1;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.drop_count !== 16'd2 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL range_drop: we=%b drops=%0d ovf=%b, required 0/2/0", bus.mem_we, bus.drop_count, bus.overflow);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        bus.mem_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.fb_we = 1'b1;
            bus.rast_x = 10'(i + 5);
            bus.rast_y = 10'd3;
            bus.fb_data = 4'(i + 1);
            step();
            checks++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 17'(965 + i) || bus.mem_wdata !== 4'(i + 1) || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b%0d: we=%b addr=%0d data=%0h ready=%b, required 1/%0d/%0h/1", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.in_ready, 965 + i, i + 1);
            end
        end
        bus.fb_we = 1'b0;
        step();
        checks++;
        if (bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty: mem_we=%b, required 0", bus.mem_we);
        end
    endtask

    task automatic test_clear_full;
        int n = 0;
        int bad = 0;
        int cyc = 0;
        int first_bad = -1;
        int exp_a;
        logic [3:0] exp_d;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            bus.fb_we = 1'b1;
            bus.rast_x = 10'(i);
            bus.rast_y = 10'd0;
            bus.fb_data = 4'(i);
            step();
        end
        bus.fb_we = 1'b0;
        bus.clear_start = 1'b1;
        bus.clear_color = 4'hA;
        step();
        bus.clear_start = 1'b0;
        bus.clear_color = 4'h0;
        bus.mem_grant = 1'b1;
        #1;
        checks++;
        if (bus.clear_busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_enter: busy=%b ready=%b, required 1/0", bus.clear_busy, bus.in_ready);
        end
        while (bus.clear_busy === 1'b1 && cyc < TOTAL + 100) begin
            if (bus.mem_we === 1'b1) begin
                exp_a = (n < 3) ? n + 1 : n - 3;
                exp_d = (n < 3) ? 4'(n + 1) : 4'hA;
                if (bus.mem_addr !== 17'(exp_a) || bus.mem_wdata !== exp_d) begin
                    bad++;
                    if (first_bad < 0) first_bad = n;
                end
                n++;
            end
            step();
            cyc++;
        end
        checks++;
        if (bus.clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: clear_busy=%b after %0d cycles, required 0", bus.clear_busy, cyc);
        end
        checks++;
        if (n != TOTAL + 3) begin
            errors++;
            $display("FAIL clear_writes: %0d writes, required %0d", n, TOTAL + 3);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_stream: %0d bad writes, first at write %0d, required 0", bad, first_bad);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_idle: ready=%b we=%b, required 1/0", bus.in_ready, bus.mem_we);
        end
    endtask

    task automatic test_clear_grant_and_reset;
        int exp = 0;
        int bad = 0;
        do_reset();
        bus.clear_start = 1'b1;
        bus.clear_color = 4'h5;
        step();
        bus.clear_start = 1'b0;
        checks++;
        if (bus.clear_busy !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: busy=%b we=%b, required 1/0", bus.clear_busy, bus.mem_we);
        end
        step();
        checks++;
        if (bus.clear_busy !== 1'b1 || bus.mem_addr !== 17'd0 || bus.mem_wdata !== 4'h5) begin
            errors++;
            $display("FAIL clear_first: busy=%b addr=%0d data=%0h, required 1/0/5", bus.clear_busy, bus.mem_addr, bus.mem_wdata);
        end
        for (int i = 0; i < 100; i++) begin
            bus.mem_grant = i[0];
            #1;
            if (bus.mem_we !== bus.mem_grant || bus.mem_addr !== 17'(exp)) bad++;
            if (bus.mem_grant) exp++;
            step();
        end
        bus.mem_grant = 1'b0;
        #1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_toggle: %0d bad cycles, required 0", bad);
        end
        checks++;
        if (bus.mem_addr !== 17'd50) begin
            errors++;
            $display("FAIL clear_advance: addr=%0d, required 50", bus.mem_addr);
        end
        bus.mem_grant = 1'b1;
        sreset_n = 1'b0;
        step();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.clear_busy !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.drop_count !== 16'd0 || bus.overflow !== 1'b0 || bus.mem_addr !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset: we=%b busy=%b ready=%b drops=%0d ovf=%b addr=%0d, required 0/0/1/0/0/0",
                     bus.mem_we, bus.clear_busy, bus.in_ready, bus.drop_count, bus.overflow, bus.mem_addr);
        end
        sreset_n = 1'b1;
    endtask

    task automatic test_saturate;
        do_reset();
        bus.fb_we = 1'b1;
        bus.rast_x = 10'd1;
        bus.rast_y = 10'd1;
        repeat (16 + 65534) step();
        checks++;
        if (bus.drop_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: drop_count=%0h, required fffe", bus.drop_count);
        end
        step();
        checks++;
        if (bus.drop_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: drop_count=%0h, required ffff", bus.drop_count);
        end
        repeat (3) step();
        checks++;
        if (bus.drop_count !== 16'hFFFF || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: drop_count=%0h ovf=%b, required ffff/1", bus.drop_count, bus.overflow);
        end
        bus.fb_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_range();
        test_back_to_back();
        test_clear_full();
        test_clear_grant_and_reset();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
